lift_request_sched: RTL and testbench
=====================================

Name: lift_request_sched

Overview:
- Upstream stage of the 4-floor lift controller FSM.
- Latches floor call buttons into a pending set and picks the next floor using SCAN (keep direction while calls remain ahead).
- Drives the lift's 2-bit target-floor input and watches the lift's one-hot floor indicators.
- Times a door-open dwell at each served floor, then clears that call.

Parameters:
- DWELL_CYCLES, 8, cycles door_open stays high per stop (≥1).
- MOVE_TIMEOUT, 16, max cycles in MOVE waiting for arrival before fault (≥2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- call_req  in  4  per-floor call pulses, bit i = floor i; may be multi-hot
- floor_onehot  in  4  lift floor indicators {trdF,sndF,fstF,gndF}; exactly one bit set expected
- target  out  2  floor code to lift datain; registered
- pending  out  4  latched outstanding calls
- door_open  out  1  high during dwell
- dir_up  out  1  current SCAN direction, 1 = up
- busy  out  1  high in MOVE or DOOR
- fault  out  1  sticky error flag

Behaviour:
- Reset, async: state=IDLE, target=0, pending=0, door_open=0, dir_up=1, busy=0, fault=0, counters=0. This matches the lift resetting to ground.
- cur = binary encode of floor_onehot. invalid = floor_onehot not exactly one-hot.
- Pending update each edge: pending <= (pending | call_req) & ~clr.
  - clr is the current-floor bit when entering DOOR, and also while in DOOR.
  - A call for the current floor during DOOR is never latched; it reloads the dwell counter instead.
- Priority: fault overrides everything.
  - invalid in any state sets fault=1, forces IDLE, door_open=0, target held.
  - While fault=1, no new MOVE; pending keeps accumulating.
  - Only rst clears fault.
- IDLE, evaluating registered pending:
  - pending[cur]=1 → DOOR, same edge clears bit.
  - Else if dir_up and any pending above cur → target = lowest pending floor above cur, MOVE.
  - Else if any pending below cur → target = highest pending below, dir_up<=0, MOVE.
  - Else if any pending above → target = lowest pending above, dir_up<=1, MOVE.
  - Else stay IDLE, dir_up unchanged.
  - Symmetric rule when dir_up=0: prefer below first.
- MOVE:
  - target held constant; new calls only set pending and never retarget mid-move.
  - Timeout counter loads 0 on entry.
  - Arrival: floor_onehot == onehot(target) → DOOR, clear pending[target].
  - Counter reaching MOVE_TIMEOUT without arrival → fault=1, IDLE.
- DOOR:
  - door_open=1; dwell counter counts DWELL_CYCLES cycles, then IDLE with door_open=0.
  - call_req[cur] during DOOR reloads the counter.
- Latency, lift updating one edge after target changes. With call at floor 2 from ground, call_req asserted before edge E0:
  - E0: pending[2]=1
  - E1: target=2, MOVE
  - E2: lift at floor 2
  - E3: DOOR, door_open=1, pending[2]=0
  - door_open stays high for DWELL_CYCLES cycles.
- busy = (state != IDLE). All outputs are registered or a direct decode of state.
- target only changes on the IDLE→MOVE edge. The lift therefore never sees a glitching or mid-move-changed floor code.

Decomposition:
- Shared package lift_pkg holds:
  - floor_t (2-bit) and constants FLOOR_GND..FLOOR_TRD, shared with the lift FSM.
  - state enum {IDLE, MOVE, DOOR}.
  - Functions onehot2floor, floor2onehot, is_onehot4.
- One natural sub-module: lift_scan_pick. Purely combinational; inputs pending, cur, dir_up; outputs next floor, next dir, found flag, serve_here flag.
- Scheduler top holds the FSM, counters and pending register.

Test Plan:
- Reset then idle: rst pulse, no calls → target=0, door_open=0, busy=0, dir_up=1 held for 20 cycles.
- Single call: at ground, call_req=4'b0100 one cycle → target=2 two edges later; door_open high exactly 8 cycles starting 4 edges after call; pending back to 0.
- SCAN order: lift at floor 1, dir_up=1, pending={0,3} → serves 3 first, then dir_up=0, target=0. Call to floor 2 arriving during the move to 3 is served before floor 0.
- Current-floor call:
  - At floor 1 in IDLE, call_req=4'b0010 → DOOR next edge, target unchanged.
  - Repeat call during dwell → dwell restarts; pending[1] stays 0.
- Fault paths:
  - floor_onehot=4'b0011 for one cycle → fault=1 sticky, no further MOVE despite pending≠0.
  - Separately, floor_onehot frozen at ground with target=3 → fault after 16 MOVE cycles.
- Reset mid-operation: rst asserted mid-MOVE and mid-DOOR → all outputs return to reset values asynchronously, pending=0, target=0.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared lift types: floor codes, scheduler states and the floor encode/decode helpers
// used by both the lift FSM and its request scheduler.
package lift_pkg;

  typedef logic [1:0] floor_t;

  localparam floor_t FLOOR_GND = 2'd0;
  localparam floor_t FLOOR_FST = 2'd1;
  localparam floor_t FLOOR_SND = 2'd2;
  localparam floor_t FLOOR_TRD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  function automatic floor_t onehot2floor(input logic [3:0] oh);
    floor_t f;
    f = FLOOR_GND;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) f = floor_t'(i);
    end
    return f;
  endfunction

  function automatic logic [3:0] floor2onehot(input floor_t f);
    return 4'b0001 << f;
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return ($countones(v) == 1);
  endfunction

endpackage

// File: rtl/lift_scan_pick.sv
// SCAN next-floor selection: keep travelling in the current direction while calls remain
// ahead, otherwise reverse; flags a call for the floor the lift is already on.
module lift_scan_pick
  import lift_pkg::*;
(
  input  logic [3:0] i_pending,
  input  floor_t     i_cur,
  input  logic       i_dir_up,
  output floor_t     o_next_floor,
  output logic       o_next_dir_up,
  output logic       o_found,
  output logic       o_serve_here
);

  logic   w_any_above;
  logic   w_any_below;
  floor_t w_lo_above;
  floor_t w_hi_below;

  always_comb begin
    w_any_above = 1'b0;
    w_any_below = 1'b0;
    w_lo_above  = FLOOR_GND;
    w_hi_below  = FLOOR_GND;
    // Descending scan leaves the lowest pending floor above cur.
    for (int i = 3; i >= 0; i--) begin
      if (i_pending[i] && (floor_t'(i) > i_cur)) begin
        w_any_above = 1'b1;
        w_lo_above  = floor_t'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i_pending[i] && (floor_t'(i) < i_cur)) begin
        w_any_below = 1'b1;
        w_hi_below  = floor_t'(i);
      end
    end
  end

  always_comb begin
    o_serve_here  = i_pending[i_cur];
    o_found       = w_any_above | w_any_below;
    o_next_floor  = FLOOR_GND;
    o_next_dir_up = i_dir_up;
    if (i_dir_up) begin
      if (w_any_above) begin
        o_next_floor  = w_lo_above;
        o_next_dir_up = 1'b1;
      end else if (w_any_below) begin
        o_next_floor  = w_hi_below;
        o_next_dir_up = 1'b0;
      end
    end else begin
      if (w_any_below) begin
        o_next_floor  = w_hi_below;
        o_next_dir_up = 1'b0;
      end else if (w_any_above) begin
        o_next_floor  = w_lo_above;
        o_next_dir_up = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lift_request_sched.sv
// Lift request scheduler: latches floor calls, issues SCAN-ordered target floors to the
// lift, times the door dwell at each stop and raises a sticky fault on bad floor feedback.
module lift_request_sched
  import lift_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 8,
  parameter int unsigned MOVE_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] call_req,
  input  logic [3:0] floor_onehot,
  output logic [1:0] target,
  output logic [3:0] pending,
  output logic       door_open,
  output logic       dir_up,
  output logic       busy,
  output logic       fault
);

  localparam int unsigned CntMax = (DWELL_CYCLES > MOVE_TIMEOUT) ? DWELL_CYCLES : MOVE_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
  localparam logic [CntW-1:0] MoveLast  = CntW'(MOVE_TIMEOUT - 1);

  state_t          r_state;
  floor_t          r_target;
  logic [3:0]      r_pending;
  logic            r_door_open;
  logic            r_dir_up;
  logic            r_fault;
  logic [CntW-1:0] r_cnt;

  floor_t     w_cur;
  logic       w_invalid;
  logic       w_arrive;
  logic [3:0] w_clr;
  floor_t     w_next_floor;
  logic       w_next_dir_up;
  logic       w_found;
  logic       w_serve_here;

  assign w_cur     = onehot2floor(floor_onehot);
  assign w_invalid = ~is_onehot4(floor_onehot);
  assign w_arrive  = (floor_onehot == floor2onehot(r_target));

  lift_scan_pick u_pick (
    .i_pending     (r_pending),
    .i_cur         (w_cur),
    .i_dir_up      (r_dir_up),
    .o_next_floor  (w_next_floor),
    .o_next_dir_up (w_next_dir_up),
    .o_found       (w_found),
    .o_serve_here  (w_serve_here)
  );

  // The served floor's bit is masked both on DOOR entry and throughout the dwell.
  always_comb begin
    w_clr = 4'b0000;
    if (!w_invalid) begin
      case (r_state)
        IDLE:    if (!r_fault && w_serve_here) w_clr = floor2onehot(w_cur);
        MOVE:    if (w_arrive) w_clr = floor2onehot(r_target);
        DOOR:    w_clr = floor2onehot(w_cur);
        default: w_clr = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_target    <= FLOOR_GND;
      r_pending   <= 4'b0000;
      r_door_open <= 1'b0;
      r_dir_up    <= 1'b1;
      r_fault     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_pending <= (r_pending | call_req) & ~w_clr;
      if (w_invalid) begin
        r_fault     <= 1'b1;
        r_state     <= IDLE;
        r_door_open <= 1'b0;
        r_cnt       <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (!r_fault) begin
              if (w_serve_here) begin
                r_state     <= DOOR;
                r_door_open <= 1'b1;
                r_cnt       <= '0;
              end else if (w_found) begin
                r_state  <= MOVE;
                r_target <= w_next_floor;
                r_dir_up <= w_next_dir_up;
                r_cnt    <= '0;
              end
            end
          end
          MOVE: begin
            if (w_arrive) begin
              r_state     <= DOOR;
              r_door_open <= 1'b1;
              r_cnt       <= '0;
            end else if (r_cnt == MoveLast) begin
              r_fault <= 1'b1;
              r_state <= IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          DOOR: begin
            if (call_req[w_cur]) begin
              r_cnt <= '0;
            end else if (r_cnt == DwellLast) begin
              r_state     <= IDLE;
              r_door_open <= 1'b0;
              r_cnt       <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state     <= IDLE;
            r_door_open <= 1'b0;
            r_cnt       <= '0;
          end
        endcase
      end
    end
  end

  assign target    = r_target;
  assign pending   = r_pending;
  assign door_open = r_door_open;
  assign dir_up    = r_dir_up;
  assign busy      = (r_state != IDLE);
  assign fault     = r_fault;

endmodule

// File: tb/tb_lift_request_sched.sv
// Directed bench for lift_request_sched with a one-edge-lag lift model; the order of served
// floors is checked through a scoreboard queue popped on every door opening.
module tb_lift_request_sched;

  logic       clk;
  logic       rst;
  logic [3:0] call_req;
  logic [3:0] floor_onehot;
  logic [1:0] target;
  logic [3:0] pending;
  logic       door_open;
  logic       dir_up;
  logic       busy;
  logic       fault;

  logic [1:0] lift_floor;
  logic       freeze;
  logic       ovr_en;
  logic [3:0] ovr_val;
  logic       prev_door;

  int n_assert = 0;
  int n_fail   = 0;
  logic [1:0] sbq[$];

  lift_request_sched #(
    .DWELL_CYCLES (8),
    .MOVE_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .call_req     (call_req),
    .floor_onehot (floor_onehot),
    .target       (target),
    .pending      (pending),
    .door_open    (door_open),
    .dir_up       (dir_up),
    .busy         (busy),
    .fault        (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Lift model: moves to the commanded floor one edge after target changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lift_floor <= 2'd0;
    else if (!freeze) lift_floor <= target;
  end

  assign floor_onehot = ovr_en ? ovr_val : (4'b0001 << lift_floor);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: each door opening must happen at the next expected floor.
  always @(negedge clk) begin
    if (!rst && door_open && !prev_door) begin
      if (sbq.size() == 0) chk("sb_unexpected_stop", 32'(lift_floor), 32'hff);
      else chk("sb_floor", 32'(lift_floor), 32'(sbq.pop_front()));
    end
    prev_door = door_open;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_call(input logic [3:0] c);
    call_req = c;
    tick();
    call_req = 4'b0000;
  endtask

  task automatic wait_served(input string tag);
    int n;
    n = 0;
    while ((busy || pending != 4'b0000) && n < 400) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy || pending != 4'b0000), 32'd0);
  endtask

  task automatic door_len(output int n);
    n = 0;
    while (door_open && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    call_req  = 4'b0000;
    freeze    = 1'b0;
    ovr_en    = 1'b0;
    ovr_val   = 4'b0000;
    prev_door = 1'b0;
    #12;
    rst = 1'b0;

    // Reset state then quiet idling.
    chk("rst_fault", 32'(fault), 32'd0);
    for (int i = 0; i < 20; i++) begin
      chk("idle_hold", 32'({target, door_open, busy, dir_up, pending}), 32'({2'd0, 3'b001, 4'd0}));
      tick();
    end

    // Single call to floor 2 from ground.
    sbq.push_back(2'd2);
    pulse_call(4'b0100);
    chk("e0_pending", 32'({pending, busy}), 32'({4'b0100, 1'b0}));
    tick();
    chk("e1_target_move", 32'({target, busy}), 32'({2'd2, 1'b1}));
    tick();
    chk("e2_door_closed", 32'(door_open), 32'd0);
    tick();
    chk("e3_door_open", 32'({door_open, pending}), 32'({1'b1, 4'b0000}));
    door_len(n);
    chk("dwell_len", 32'(n), 32'd8);
    chk("after_single", 32'({busy, dir_up, target}), 32'({1'b0, 1'b1, 2'd2}));

    // SCAN order: position at floor 1 going up, then calls at 0 and 3, plus 2 during the move.
    do_reset();
    tick();
    sbq.push_back(2'd1);
    pulse_call(4'b0010);
    wait_served("tmo_to_f1");
    chk("f1_dir_up", 32'({dir_up, target}), 32'({1'b1, 2'd1}));
    sbq.push_back(2'd3);
    sbq.push_back(2'd2);
    sbq.push_back(2'd0);
    pulse_call(4'b1001);
    tick();
    chk("scan_first_target", 32'({target, dir_up, busy}), 32'({2'd3, 1'b1, 1'b1}));
    pulse_call(4'b0100);
    chk("mid_move_no_retarget", 32'({target, pending}), 32'({2'd3, 4'b1101}));
    wait_served("tmo_scan");
    chk("scan_end", 32'({target, dir_up}), 32'({2'd0, 1'b0}));

    // Current-floor call, then a repeat call mid-dwell restarts the dwell.
    sbq.push_back(2'd1);
    pulse_call(4'b0010);
    wait_served("tmo_to_f1b");
    pulse_call(4'b0010);
    sbq.push_back(2'd1);
    chk("here_e0", 32'({pending, busy}), 32'({4'b0010, 1'b0}));
    tick();
    chk("here_door", 32'({door_open, target, pending}), 32'({1'b1, 2'd1, 4'b0000}));
    tick();
    tick();
    tick();
    pulse_call(4'b0010);
    chk("redwell_no_latch", 32'({door_open, pending}), 32'({1'b1, 4'b0000}));
    door_len(n);
    chk("redwell_len", 32'(n), 32'd8);

    // Invalid floor indication: sticky fault, no further moves.
    ovr_en  = 1'b1;
    ovr_val = 4'b0011;
    tick();
    ovr_en = 1'b0;
    chk("inv_fault", 32'({fault, busy, target}), 32'({1'b1, 1'b0, 2'd1}));
    pulse_call(4'b1000);
    for (int i = 0; i < 20; i++) tick();
    chk("fault_no_move", 32'({fault, busy, pending, target}), 32'({1'b1, 1'b0, 4'b1000, 2'd1}));

    // Lift frozen at ground: timeout after 16 cycles in MOVE.
    do_reset();
    tick();
    chk("rst_clears_fault", 32'({fault, pending}), 32'({1'b0, 4'b0000}));
    freeze = 1'b1;
    pulse_call(4'b1000);
    tick();
    door_len(n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    chk("move_timeout_len", 32'(n), 32'd16);
    chk("timeout_fault", 32'({fault, target, pending}), 32'({1'b1, 2'd3, 4'b1000}));

    // Async reset mid-MOVE.
    do_reset();
    tick();
    pulse_call(4'b1000);
    tick();
    tick();
    tick();
    chk("pre_rst_move", 32'({busy, target}), 32'({1'b1, 2'd3}));
    rst = 1'b1;
    #2;
    chk("rst_mid_move", 32'({target, pending, door_open, dir_up, busy, fault}),
        32'({2'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}));
    rst    = 1'b0;
    freeze = 1'b0;
    tick();

    // Async reset mid-DOOR.
    sbq.push_back(2'd2);
    pulse_call(4'b0100);
    tick();
    tick();
    tick();
    chk("pre_rst_door", 32'(door_open), 32'd1);
    tick();
    rst = 1'b1;
    #2;
    chk("rst_mid_door", 32'({target, pending, door_open, dir_up, busy, fault}),
        32'({2'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}));
    rst = 1'b0;
    tick();
    tick();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
